// File: rtl/ice40_rgb_seq.sv
// Wishbone master that reprograms the iCE40 RGB driver block with a fixed
// nine-write sequence per accepted request, aborting on a missing ack.
module ice40_rgb_seq #(
  parameter logic [7:0] LEDDCR0     = 8'hC8,
  parameter logic [7:0] LEDDBR      = 8'hE0,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_r,
  input  logic [7:0]  req_g,
  input  logic [7:0]  req_b,
  input  logic [7:0]  req_on,
  input  logic [7:0]  req_off,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WR, GAP} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);
  localparam logic [3:0] LAST_IDX  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d, on_q, on_d, off_q, off_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d, cyc_q, cyc_d;
  logic        done_q, done_d, err_q, err_d, ready_q, ready_d;

  // Index 0 clears LEDDEXE before reprogramming; index 8 sets it again.
  function automatic logic [12:0] seq_entry(input logic [3:0] idx,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input logic [7:0] on,
                                            input logic [7:0] off);
    case (idx)
      4'd0:    return {5'h00, 8'h0C};
      4'd1:    return {5'h18, LEDDCR0};
      4'd2:    return {5'h19, LEDDBR};
      4'd3:    return {5'h1A, on};
      4'd4:    return {5'h1B, off};
      4'd5:    return {5'h11, r};
      4'd6:    return {5'h12, g};
      4'd7:    return {5'h13, b};
      default: return {5'h00, 8'h0E};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    on_d    = on_q;
    off_d   = off_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          r_d     = req_r;
          g_d     = req_g;
          b_d     = req_b;
          on_d    = req_on;
          off_d   = req_off;
          state_d = WR;
          idx_d   = 4'd0;
          tmo_d   = 8'd0;
          {addr_d, data_d} = seq_entry(4'd0, req_r, req_g, req_b, req_on, req_off);
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          ready_d = 1'b0;
        end
      end
      WR: begin
        if (wb_ack) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_LIMIT) begin
            state_d = IDLE;
            err_d   = 1'b1;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            ready_d = 1'b1;
          end
        end
      end
      GAP: begin
        idx_d   = idx_q + 4'd1;
        tmo_d   = 8'd0;
        {addr_d, data_d} = seq_entry(idx_d, r_q, g_q, b_q, on_q, off_q);
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WR;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      tmo_q   <= 8'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
      on_q    <= 8'd0;
      off_q   <= 8'd0;
      addr_q  <= 5'd0;
      data_q  <= 8'd0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      on_q    <= on_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign wb_addr   = addr_q;
  assign wb_wdata  = {24'h0, data_q};
  assign wb_we     = we_q;
  assign wb_cyc    = cyc_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ice40_rgb_seq.sv
// Directed scenarios with random request data, checked against a table model
// of the nine-write sequence and the expected cycle timing.
module tb_ice40_rgb_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_r = 8'd0, req_g = 8'd0, req_b = 8'd0, req_on = 8'd0, req_off = 8'd0;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we, wb_cyc, wb_ack, done, err;

  int ack_mode = 0;   // 0: ack tied to cyc, 1: ack on 4th cyc cycle, 2: never
  int hold_cnt = 0;
  int cyc_n    = 0;
  int checks   = 0;
  int failures = 0;

  ice40_rgb_seq dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_r(req_r), .req_g(req_g), .req_b(req_b), .req_on(req_on), .req_off(req_off),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_n    <= cyc_n + 1;
    hold_cnt <= wb_cyc ? hold_cnt + 1 : 0;
  end

  assign wb_ack = (ack_mode == 0) ? wb_cyc :
                  (ack_mode == 1) ? (wb_cyc && hold_cnt == 3) : 1'b0;

  // Bus monitor: completed writes with their start/ack cycles, plus protocol counters.
  logic [36:0] wr_q[$];
  int          rise_q[$];
  int          ackc_q[$];
  int          rise_n = 0, rises = 0, cyc_hi = 0, we_bad = 0, stab_bad = 0;
  int          done_n = 0, err_n = 0, both_n = 0;
  logic        prev_cyc = 1'b0, prev_ack = 1'b0;
  logic [36:0] prev_aw = '0;

  always @(negedge clk) begin
    if (wb_we && !wb_cyc) we_bad <= we_bad + 1;
    if (done && err) both_n <= both_n + 1;
    if (done) done_n <= done_n + 1;
    if (err) err_n <= err_n + 1;
    if (wb_cyc) cyc_hi <= cyc_hi + 1;
    if (wb_cyc && !prev_cyc) begin
      rise_n <= cyc_n;
      rises  <= rises + 1;
    end
    if (wb_cyc && prev_cyc && !prev_ack && ({wb_addr, wb_wdata} !== prev_aw))
      stab_bad <= stab_bad + 1;
    if (wb_cyc && wb_ack) begin
      wr_q.push_back({wb_addr, wb_wdata});
      rise_q.push_back((wb_cyc && !prev_cyc) ? cyc_n : rise_n);
      ackc_q.push_back(cyc_n);
    end
    prev_cyc <= wb_cyc;
    prev_ack <= wb_ack;
    prev_aw  <= {wb_addr, wb_wdata};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: d = {r, g, b, on, off}
  function automatic logic [36:0] exp_wr(input logic [39:0] d, input int i);
    logic [4:0] a [9];
    logic [7:0] v [9];
    a = '{5'h00, 5'h18, 5'h19, 5'h1A, 5'h1B, 5'h11, 5'h12, 5'h13, 5'h00};
    v = '{8'h0C, 8'hC8, 8'hE0, d[15:8], d[7:0], d[39:32], d[31:24], d[23:16], 8'h0E};
    return {a[i], 24'h0, v[i]};
  endfunction

  function automatic logic [39:0] rnd_req();
    return {32'($urandom), 8'($urandom)};
  endfunction

  task automatic drive(input logic [39:0] d);
    {req_r, req_g, req_b, req_on, req_off} = d;
  endtask

  // Raises req_valid with d; returns cyc_n of the first cycle after acceptance.
  task automatic request(input logic [39:0] d, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    drive(d);
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 acc = cyc_n;
  endtask

  task automatic wait_end(input int limit, output int at, output logic was_done);
    int n;
    n = 0;
    at = -1;
    was_done = 1'b0;
    while (n < limit && at < 0) begin
      @(negedge clk);
      #1;
      if (done || err) begin
        at = cyc_n;
        was_done = done;
      end
      n++;
    end
    chk("end_seen", (at >= 0), 1);
  endtask

  task automatic check_seq(input string tag, input logic [39:0] d, input int base,
                           input int acc, input int hold);
    chk({tag, "_count"}, (wr_q.size() >= base + 9), 1);
    if (wr_q.size() >= base + 9) begin
      chk({tag, "_start"}, rise_q[base], acc);
      for (int i = 0; i < 9; i++) begin
        chk({tag, "_wr"}, wr_q[base + i], exp_wr(d, i));
        chk({tag, "_hold"}, ackc_q[base + i] - rise_q[base + i] + 1, hold);
        if (i > 0) chk({tag, "_gap"}, rise_q[base + i] - ackc_q[base + i - 1], 2);
      end
    end
  endtask

  initial begin
    int          acc, acc2, at, at2, base, b_done, b_err, b_rise, b_hi;
    logic        wd;
    logic [39:0] d, d2;
    int          accs[4];
    logic [39:0] ds[4];
    int          hold;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_cyc_we", {wb_cyc, wb_we}, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_done_err", {done, err}, 0);

    // Zero-wait ack, fixed data
    ack_mode = 0;
    d = 40'h1020304050;
    base = wr_q.size(); b_done = done_n; b_hi = cyc_hi;
    request(d, acc);
    @(negedge clk) req_valid = 1'b0;
    wait_end(100, at, wd);
    chk("s1_done_cycle", at - acc + 1, 18);
    chk("s1_is_done", wd, 1);
    chk("s1_ready_at_done", req_ready, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("s1_nwrites", wr_q.size() - base, 9);
    chk("s1_cyc_cycles", cyc_hi - b_hi, 9);
    chk("s1_done_once", done_n - b_done, 1);
    check_seq("s1", d, base, acc, 1);

    // Ack delayed three cycles per write
    ack_mode = 1;
    d = rnd_req();
    base = wr_q.size(); b_done = done_n;
    request(d, acc);
    @(negedge clk) req_valid = 1'b0;
    wait_end(400, at, wd);
    chk("s2_done_cycle", at - acc + 1, 45);
    chk("s2_is_done", wd, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("s2_done_once", done_n - b_done, 1);
    check_seq("s2", d, base, acc, 4);

    // Ack never arrives
    ack_mode = 2;
    d = rnd_req();
    base = wr_q.size(); b_done = done_n; b_err = err_n; b_rise = rises; b_hi = cyc_hi;
    request(d, acc);
    chk("s3_first_write", {wb_cyc, wb_we, wb_addr, wb_wdata}, {1'b1, 1'b1, 5'h00, 32'h0C});
    @(negedge clk) req_valid = 1'b0;
    wait_end(100, at, wd);
    chk("s3_err_cycle", at - acc + 1, 16);
    chk("s3_is_err", {wd, err}, 2'b01);
    chk("s3_ready_at_err", req_ready, 1);
    chk("s3_cyc_cycles", cyc_hi - b_hi, 15);
    repeat (20) @(negedge clk);
    #1;
    chk("s3_one_write", rises - b_rise, 1);
    chk("s3_no_acked", wr_q.size() - base, 0);
    chk("s3_err_once", err_n - b_err, 1);
    chk("s3_no_done", done_n - b_done, 0);

    // Second request held valid with new data during the first sequence
    ack_mode = 0;
    d = rnd_req();
    d2 = rnd_req();
    base = wr_q.size(); b_done = done_n;
    request(d, acc);
    @(negedge clk) drive(d2);
    wait_end(100, at, wd);
    chk("s4_done_cycle", at - acc + 1, 18);
    chk("s4_ready_at_done", req_ready, 1);
    @(posedge clk);
    #1 acc2 = cyc_n;
    @(negedge clk) req_valid = 1'b0;
    wait_end(100, at2, wd);
    chk("s4_second_done", at2 - acc2 + 1, 18);
    repeat (2) @(negedge clk);
    #1;
    chk("s4_done_twice", done_n - b_done, 2);
    check_seq("s4a", d, base, acc, 1);
    check_seq("s4b", d2, base + 9, at + 1, 1);

    // Reset during write index 5
    d = rnd_req();
    b_done = done_n; b_err = err_n;
    request(d, acc);
    @(negedge clk) req_valid = 1'b0;
    while (cyc_n < acc + 10) @(negedge clk);
    #1;
    chk("s5_at_idx5", {wb_cyc, wb_addr, wb_wdata[7:0]}, {1'b1, 5'h11, d[39:32]});
    rst = 1'b1;
    #1;
    chk("s5_async_drop", {wb_cyc, wb_we}, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("s5_post_rst", {req_ready, wb_addr, wb_wdata}, {1'b1, 5'h00, 32'h0});
    repeat (6) @(negedge clk);
    #1;
    chk("s5_no_pulse", {done_n - b_done, err_n - b_err}, 0);
    d = rnd_req();
    base = wr_q.size();
    request(d, acc);
    @(negedge clk) req_valid = 1'b0;
    wait_end(100, at, wd);
    chk("s5_restart_done", at - acc + 1, 18);
    repeat (2) @(negedge clk);
    check_seq("s5", d, base, acc, 1);

    // Back-to-back requests
    ack_mode = $urandom_range(0, 1);
    hold = (ack_mode == 1) ? 4 : 1;
    for (int k = 0; k < 4; k++) ds[k] = rnd_req();
    base = wr_q.size(); b_done = done_n;
    request(ds[0], accs[0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk) drive(ds[k]);
      wait_end(400, at, wd);
      chk("s6_ready_at_done", req_ready, 1);
      @(posedge clk);
      #1 accs[k] = cyc_n;
    end
    @(negedge clk) req_valid = 1'b0;
    wait_end(400, at, wd);
    repeat (3) @(negedge clk);
    #1;
    chk("s6_done_count", done_n - b_done, 4);
    for (int k = 0; k < 4; k++) check_seq("s6", ds[k], base + 9 * k, accs[k], hold);

    chk("we_without_cyc", we_bad, 0);
    chk("addr_data_stable", stab_bad, 0);
    chk("done_and_err", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ice40_rgb_seq.md
ICE40_RGB_SEQ -- requirements
Module: ice40_rgb_seq

Interface
REQ-001 SHALL provide parameter LEDDCR0, default 8'hC8, value written to LEDDA register LEDDCR0 on every update.
REQ-002 SHALL provide parameter LEDDBR, default 8'hE0, value written to LEDDA register LEDDBR on every update.
REQ-003 SHALL provide parameter ACK_TIMEOUT, default 15, the maximum cycles to wait for wb_ack per write (range 1..255).
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  update request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_r, req_g, req_b  in  8 each  PWM duty per channel.
- req_on, req_off  in  8 each  blink on/off times.
- wb_addr  out  5  Wishbone address to the RGB driver block.
- wb_wdata  out  32  write data; bits [31:8] always 0.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle strobe.
- wb_ack  in  1  acknowledge; may be combinational on wb_cyc.
- done  out  1  one-cycle pulse: sequence completed.
- err  out  1  one-cycle pulse: sequence aborted on ack timeout.

Function
REQ-005 SHALL be an upstream Wishbone master that programs the RGB driver block (address bit 4 = LEDDA register, else control register) with a fixed 9-write sequence per request.
REQ-006 SHALL capture all req_* data on acceptance; later req_* changes SHALL NOT affect the sequence in progress.
REQ-007 Write sequence, index 0..8 (addr: data): 0x00:0x0C; 0x18:LEDDCR0; 0x19:LEDDBR; 0x1A:req_on; 0x1B:req_off; 0x11:req_r; 0x12:req_g; 0x13:req_b; 0x00:0x0E.
REQ-008 Control data meaning: bit1 LEDDEXE, bit2 RGBLEDEN, bit3 CURREN; write 0 deasserts EXE before reprogramming, write 8 re-enables it.
REQ-009 SHALL use states IDLE, WR, GAP with a 4-bit write index.
REQ-010 IDLE: req_ready=1, wb_cyc=0; on req_valid go to WR with index 0.
REQ-011 WR: wb_cyc=1, wb_we=1, addr/data per index; on wb_ack: index 8 -> IDLE with done pulse, else -> GAP.
REQ-012 GAP: wb_cyc=0 for exactly one cycle, index increments, then WR.
REQ-013 wb_addr, wb_wdata, wb_we SHALL be held stable throughout each WR cycle; wb_we=0 whenever wb_cyc=0.
REQ-014 With zero-wait ack: acceptance at edge 0 -> wb_cyc high in cycles 1,3,...,17; done high in cycle 18, together with req_ready.
REQ-015 Timeout counter SHALL clear on entering WR and increment each WR cycle without ack; reaching ACK_TIMEOUT without ack SHALL drop wb_cyc, pulse err for one cycle, return to IDLE; remaining writes SHALL NOT be issued.
REQ-016 wb_ack SHALL be ignored outside WR.
REQ-017 done and err SHALL never assert in the same cycle.
REQ-018 req_ready SHALL be 0 in WR and GAP; requests arriving there stay pending until IDLE.

Reset
REQ-019 rst SHALL force IDLE, index 0, timeout count 0, captured data 0, wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, done=0, err=0, req_ready=1 once rst deasserts.
REQ-020 rst asserted mid-sequence SHALL drop wb_cyc immediately (asynchronously); no done or err pulse results.

Verification
REQ-021 Bench SHALL cover:
- Ack tied to wb_cyc, request r=0x10 g=0x20 b=0x30 on=0x40 off=0x50 -> exact 9 writes of REQ-007, cyc cycles 1,3..17, done at 18.
- Ack delayed 3 cycles per write -> same 9 writes, each cyc held 4 cycles with stable addr/data, done once.
- Ack never asserted, ACK_TIMEOUT=15 -> single write to 0x00 held 15 cycles, err pulse, no further writes, req_ready back to 1.
- Second request held valid during sequence with changed data -> first sequence uses first data unchanged; second accepted in done cycle's IDLE, then runs.
- rst pulsed during write index 5 -> wb_cyc low immediately, no done/err; next request restarts at index 0.
- Back-to-back requests -> exactly one GAP cycle between consecutive writes, wb_we never high while wb_cyc low.
